crew_mode_panel: RTL and testbench

- Crew-panel front end that turns four raw cabin-crew push-buttons and an emergency clear key into the 2-bit lighting mode command.
- Synchronizes and debounces each input, applies priority arbitration and a dimming auto-timeout, and holds a latched emergency state.
- `mode_select` feeds the lighting controller's `mode_select` input directly.
- `mode_valid` and `cmd_count` are for the panel display and logging.

---
 rtl/crew_mode_panel.sv | 137 +++++++++++++
 tb/tb_crew_mode_panel.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crew_mode_panel.sv
// Crew-panel front end: synchronizes and debounces five raw switches, arbitrates
// rising-edge events by priority and drives the registered 2-bit lighting mode.
module crew_mode_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIM_TIMEOUT     = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_off,
    input  logic       btn_normal,
    input  logic       btn_dim,
    input  logic       btn_emerg,
    input  logic       emerg_clear,
    output logic [1:0] mode_select,
    output logic       mode_valid,
    output logic       emerg_active,
    output logic [7:0] cmd_count
);

    localparam int N_IN    = 5;
    localparam int I_OFF   = 0;
    localparam int I_NORM  = 1;
    localparam int I_DIM   = 2;
    localparam int I_EMERG = 3;
    localparam int I_CLEAR = 4;

    localparam logic [3:0]  DB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] DIM_LAST = 16'(DIM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        NORMAL    = 2'b01,
        DIMMING   = 2'b10,
        EMERGENCY = 2'b11
    } mode_t;

    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] s1;
    logic [N_IN-1:0] s2;
    logic [N_IN-1:0] db;
    logic [N_IN-1:0] db_d;
    logic [N_IN-1:0] ev;
    logic [3:0]      cnt [N_IN];

    mode_t       state;
    mode_t       next_state;
    logic        dim_restart;
    logic [15:0] dim_timer;

    assign raw = {emerg_clear, btn_emerg, btn_dim, btn_normal, btn_off};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            db_d <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_d <= db;
        end
    end

    // The debounced level only follows s2 after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db <= '0;
            for (int i = 0; i < N_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    assign ev = db & ~db_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mode_valid   <= 1'b0;
            emerg_active <= 1'b0;
            cmd_count    <= '0;
            dim_timer    <= '0;
        end else begin
            state        <= next_state;
            mode_valid   <= (next_state != state);
            emerg_active <= (next_state == EMERGENCY);
            if (next_state != state) begin
                cmd_count <= cmd_count + 8'd1;
            end
            if (dim_restart) begin
                dim_timer <= '0;
            end else if (state == DIMMING) begin
                dim_timer <= dim_timer + 16'd1;
            end else begin
                dim_timer <= '0;
            end
        end
    end

    // Priority chain emerg > off > dim > normal; the timeout only fires with no button event.
    always_comb begin
        next_state  = state;
        dim_restart = 1'b0;
        if (state == EMERGENCY) begin
            if (ev[I_CLEAR] && (ev[I_EMERG:I_OFF] == 4'd0)) begin
                next_state = NORMAL;
            end
        end else if (ev[I_EMERG]) begin
            next_state = EMERGENCY;
        end else if (ev[I_OFF]) begin
            next_state = IDLE;
        end else if (ev[I_DIM]) begin
            next_state  = DIMMING;
            dim_restart = 1'b1;
        end else if (ev[I_NORM]) begin
            next_state = NORMAL;
        end else if ((state == DIMMING) && (dim_timer == DIM_LAST)) begin
            next_state = NORMAL;
        end
    end

    always_comb begin
        mode_select = state;
    end

endmodule

// File: tb/tb_crew_mode_panel.sv
// Bench for crew_mode_panel: directed vector table, hand-timed corner sequences,
// and randomized presses checked every cycle against a window/edge-stamp model.
module tb_crew_mode_panel;

    localparam int DB = 4;
    localparam int DT = 20;

    localparam logic [4:0] B_OFF   = 5'b00001;
    localparam logic [4:0] B_NORM  = 5'b00010;
    localparam logic [4:0] B_DIM   = 5'b00100;
    localparam logic [4:0] B_EMERG = 5'b01000;
    localparam logic [4:0] B_CLEAR = 5'b10000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_off = 1'b0;
    logic       btn_normal = 1'b0;
    logic       btn_dim = 1'b0;
    logic       btn_emerg = 1'b0;
    logic       emerg_clear = 1'b0;
    logic [1:0] mode_select;
    logic       mode_valid;
    logic       emerg_active;
    logic [7:0] cmd_count;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    crew_mode_panel #(
        .DEBOUNCE_CYCLES(DB),
        .DIM_TIMEOUT    (DT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_off     (btn_off),
        .btn_normal  (btn_normal),
        .btn_dim     (btn_dim),
        .btn_emerg   (btn_emerg),
        .emerg_clear (emerg_clear),
        .mode_select (mode_select),
        .mode_valid  (mode_valid),
        .emerg_active(emerg_active),
        .cmd_count   (cmd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [4:0] b);
        {emerg_clear, btn_emerg, btn_dim, btn_normal, btn_off} = b;
    endtask

    // Reference model: a raw-sample history window decides the debounced level,
    // and the dim timeout is measured from the edge number DIMMING was entered.
    logic [1:0]    m_mode;
    bit            m_valid;
    logic [7:0]    m_cnt;
    int            m_n;
    int            m_enter;
    logic [DB+1:0] m_hist [5];
    bit   [4:0]    m_db;
    bit   [4:0]    m_dbd;

    always @(posedge clk or posedge reset) begin : model
        bit [4:0]   ev;
        bit [4:0]   rawv;
        logic [1:0] nm;
        bit         diff_all;
        if (reset) begin
            m_mode  = 2'd0;
            m_valid = 1'b0;
            m_cnt   = 8'd0;
            m_n     = 0;
            m_enter = 0;
            m_db    = '0;
            m_dbd   = '0;
            for (int i = 0; i < 5; i++) m_hist[i] = '0;
        end else begin
            m_n++;
            ev = m_db & ~m_dbd;
            nm = m_mode;
            if (m_mode == 2'd3) begin
                if (ev[4] && (ev[3:0] == 4'd0)) nm = 2'd1;
            end else if (ev[3]) nm = 2'd3;
            else if (ev[0]) nm = 2'd0;
            else if (ev[2]) begin
                nm = 2'd2;
                m_enter = m_n;
            end else if (ev[1]) nm = 2'd1;
            else if ((m_mode == 2'd2) && ((m_n - m_enter) == DT)) nm = 2'd1;
            m_valid = (nm != m_mode);
            if (m_valid) m_cnt++;
            m_mode = nm;
            rawv  = {emerg_clear, btn_emerg, btn_dim, btn_normal, btn_off};
            m_dbd = m_db;
            for (int i = 0; i < 5; i++) begin
                m_hist[i] = {m_hist[i][DB:0], rawv[i]};
                diff_all = 1'b1;
                for (int k = 2; k <= DB + 1; k++) begin
                    if (m_hist[i][k] == m_db[i]) diff_all = 1'b0;
                end
                if (diff_all) m_db[i] = ~m_db[i];
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("model_cycle", 32'({mode_select, mode_valid, emerg_active, cmd_count}),
                  32'({m_mode, m_valid, (m_mode == 2'd3), m_cnt}));
        end
    end

    typedef struct {
        logic [4:0] btns;
        int         hold;
        logic [1:0] exp_mode;
        logic       exp_emerg;
        logic [7:0] exp_count;
    } vec_t;

    vec_t vecs [14];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        int bad;
        vecs[0]  = '{B_DIM,            3, 2'd1, 1'b0, 8'd1};
        vecs[1]  = '{B_OFF | B_EMERG,  6, 2'd3, 1'b1, 8'd2};
        vecs[2]  = '{B_NORM,           6, 2'd3, 1'b1, 8'd2};
        vecs[3]  = '{B_OFF,            6, 2'd3, 1'b1, 8'd2};
        vecs[4]  = '{B_DIM,            6, 2'd3, 1'b1, 8'd2};
        vecs[5]  = '{B_CLEAR,          6, 2'd1, 1'b0, 8'd3};
        vecs[6]  = '{B_CLEAR,          6, 2'd1, 1'b0, 8'd3};
        vecs[7]  = '{B_OFF,            6, 2'd0, 1'b0, 8'd4};
        vecs[8]  = '{B_OFF,            6, 2'd0, 1'b0, 8'd4};
        vecs[9]  = '{B_DIM | B_NORM,   6, 2'd2, 1'b0, 8'd5};
        vecs[10] = '{B_NORM,           6, 2'd1, 1'b0, 8'd6};
        vecs[11] = '{B_NORM,           6, 2'd1, 1'b0, 8'd6};
        vecs[12] = '{B_EMERG | B_CLEAR,6, 2'd3, 1'b1, 8'd7};
        vecs[13] = '{B_CLEAR,          6, 2'd1, 1'b0, 8'd8};

        set_btns('0);
        reset = 1'b1;
        repeat (3) tick();
        check("reset_state", 32'({mode_select, mode_valid, emerg_active, cmd_count}), 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Power-up latency: first sample at edge 1, mode change at edge 7.
        set_btns(B_NORM);
        repeat (6) tick();
        check("pwr_edge6_mode", 32'(mode_select), 32'd0);
        tick();
        check("pwr_edge7_mode", 32'(mode_select), 32'd1);
        check("pwr_edge7_valid", 32'(mode_valid), 32'd1);
        check("pwr_edge7_count", 32'(cmd_count), 32'd1);
        tick();
        check("pwr_edge8_valid", 32'(mode_valid), 32'd0);
        repeat (2) tick();
        set_btns('0);
        repeat (10) tick();

        for (int v = 0; v < 14; v++) begin
            set_btns(vecs[v].btns);
            repeat (vecs[v].hold) tick();
            set_btns('0);
            repeat (12) tick();
            check($sformatf("vec%0d_mode", v), 32'(mode_select), 32'(vecs[v].exp_mode));
            check($sformatf("vec%0d_emerg", v), 32'(emerg_active), 32'(vecs[v].exp_emerg));
            check($sformatf("vec%0d_count", v), 32'(cmd_count), 32'(vecs[v].exp_count));
        end

        // Plain dim timeout: entry at edge 7, return at edge 27.
        set_btns(B_DIM);
        repeat (4) tick();
        set_btns('0);
        repeat (2) tick();
        check("dim_pre", 32'(mode_select), 32'd1);
        tick();
        check("dim_enter", 32'({mode_select, mode_valid}), 32'({2'd2, 1'b1}));
        repeat (19) tick();
        check("dim_hold", 32'(mode_select), 32'd2);
        tick();
        check("dim_expire", 32'({mode_select, mode_valid}), 32'({2'd1, 1'b1}));
        repeat (3) tick();

        // Re-press dim 10 edges after entry: re-entry at 17, silent, expiry at 37.
        set_btns(B_DIM);
        repeat (4) tick();
        set_btns('0);
        repeat (3) tick();
        check("redim_enter", 32'({mode_select, mode_valid}), 32'({2'd2, 1'b1}));
        bad = 0;
        for (int e = 8; e <= 36; e++) begin
            if (e == 11) set_btns(B_DIM);
            if (e == 15) set_btns('0);
            tick();
            if ((mode_select != 2'd2) || mode_valid) bad++;
        end
        check("redim_hold", 32'(bad), 32'd0);
        tick();
        check("redim_expire", 32'({mode_select, mode_valid}), 32'({2'd1, 1'b1}));
        repeat (3) tick();

        // Off event landing on the expiry edge wins over the timeout.
        set_btns(B_DIM);
        repeat (4) tick();
        set_btns('0);
        repeat (16) tick();
        set_btns(B_OFF);
        repeat (4) tick();
        set_btns('0);
        repeat (2) tick();
        check("coll_pre", 32'(mode_select), 32'd2);
        tick();
        check("coll_off", 32'({mode_select, mode_valid}), 32'({2'd0, 1'b1}));
        bad = 0;
        repeat (10) begin
            tick();
            if (mode_select == 2'd1) bad++;
        end
        check("coll_never_normal", 32'(bad), 32'd0);

        // Async reset in the middle of a clear-key debounce while in EMERGENCY.
        set_btns(B_EMERG);
        repeat (4) tick();
        set_btns('0);
        repeat (8) tick();
        check("emerg_set", 32'({mode_select, emerg_active}), 32'({2'd3, 1'b1}));
        set_btns(B_CLEAR);
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check("rst_async", 32'({mode_select, mode_valid, emerg_active, cmd_count}), 32'd0);
        set_btns('0);
        repeat (2) tick();
        reset = 1'b0;
        bad = 0;
        repeat (20) begin
            tick();
            if ((mode_select != 2'd0) || mode_valid || (cmd_count != 8'd0)) bad++;
        end
        check("rst_quiet", 32'(bad), 32'd0);
        set_btns(B_NORM);
        repeat (4) tick();
        set_btns('0);
        repeat (8) tick();
        check("rst_new_press", 32'({mode_select, cmd_count}), 32'({2'd1, 8'd1}));

        // 256 alternating changes from IDLE wrap the counter back to zero.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            set_btns((i % 2 == 0) ? B_NORM : B_DIM);
            repeat (4) tick();
            set_btns('0);
            repeat (7) tick();
        end
        check("wrap_count", 32'({mode_select, cmd_count}), 32'({2'd2, 8'd0}));

        // Randomized presses, overlaps, glitches and occasional async resets.
        for (int it = 0; it < 250; it++) begin
            logic [4:0] b;
            b = 5'(1 << $urandom_range(0, 4));
            if ($urandom_range(0, 4) == 0) b = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                #3;
                reset = 1'b0;
            end
            set_btns(b);
            repeat ($urandom_range(1, 8)) tick();
            set_btns('0);
            repeat ($urandom_range(0, 25)) tick();
        end
        repeat (30) tick();

        mon_en = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
